// File: rtl/player_motion_fsm.sv
// rtl/player_motion_fsm.sv - player car motion, crash animation and respawn FSM; optional blink via RESPAWN_BLINK_EN
module player_motion_fsm #(
  parameter int W              = 11,
  parameter int MIN_X          = 242,
  parameter int MAX_X          = 484,
  parameter int X_START        = 256,
  parameter int Y_POS          = 380,
  parameter int CAR_W          = 32,
  parameter int CAR_H          = 36,
  parameter int MAX_SPEED      = 4,
  parameter int IMG_ALIVE      = 0,
  parameter int IMG_CRASH0     = 99,
  parameter int CRASH_IMGS     = 12,
  parameter int FRAMES_PER_IMG = 16,
  parameter int INVULN_FRAMES  = 120
`ifdef RESPAWN_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 8
`endif
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         frame_start,
  input  logic         plus_is_pressed,
  input  logic         minus_is_pressed,
  input  logic         collision,
  output logic [W-1:0] img_id,
  output logic [W-1:0] player_x,
  output logic [W-1:0] player_y,
  output logic [W-1:0] width,
  output logic [W-1:0] height,
  output logic         crashing,
  output logic         invulnerable,
  output logic         visible,
  output logic [3:0]   crash_count
);

  localparam int SW        = $clog2(MAX_SPEED + 1);
  localparam int WX        = W + 1;
  localparam int CRASH_LEN = CRASH_IMGS * FRAMES_PER_IMG;
  localparam int CNT_MAX   = (CRASH_LEN > INVULN_FRAMES) ? CRASH_LEN : INVULN_FRAMES;
  localparam int FCW       = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_ALIVE   = 2'd0;
  localparam logic [1:0] ST_CRASH   = 2'd1;
  localparam logic [1:0] ST_RESPAWN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [SW-1:0]  spd_q, spd_d;
  logic           dir_q, dir_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   img_q, img_d;
  logic [3:0]     cc_q, cc_d;

  logic           go_r, go_l;
  logic [SW-1:0]  spd_mv;
  logic           dir_mv;
  logic [W-1:0]   x_mv;
  logic           wall_hit;
  logic           enter_crash;
  logic [FCW-1:0] cnt_inc;

  // exactly one key held steers; both or none means stop
  assign go_r    = plus_is_pressed & ~minus_is_pressed;
  assign go_l    = minus_is_pressed & ~plus_is_pressed;
  assign cnt_inc = cnt_q + FCW'(1);

  // candidate move for this frame: accelerate, then clamp to the road in W+1 bits
  always_comb begin
    spd_mv   = '0;
    dir_mv   = dir_q;
    x_mv     = x_q;
    wall_hit = 1'b0;
    if (go_r || go_l) begin
      if (spd_q == '0 || go_r != dir_q) spd_mv = SW'(1);
      else if (spd_q == SW'(MAX_SPEED)) spd_mv = spd_q;
      else spd_mv = spd_q + SW'(1);
      dir_mv = go_r;
    end
    if (go_r) begin
      if (WX'(x_q) + WX'(spd_mv) + WX'(CAR_W) > WX'(MAX_X)) begin
        x_mv     = W'(MAX_X - CAR_W);
        wall_hit = 1'b1;
      end else begin
        x_mv = x_q + W'(spd_mv);
      end
    end else if (go_l) begin
      if (WX'(x_q) < WX'(MIN_X) + WX'(spd_mv)) begin
        x_mv     = W'(MIN_X);
        wall_hit = 1'b1;
      end else begin
        x_mv = x_q - W'(spd_mv);
      end
    end
  end

  // frame-rate state machine; nothing moves between frame_start pulses
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    spd_d       = spd_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    img_d       = img_q;
    cc_d        = cc_q;
    enter_crash = 1'b0;
    if (frame_start) begin
      case (state_q)
        ST_ALIVE: begin
          if (collision) begin
            enter_crash = 1'b1;
          end else begin
            x_d         = x_mv;
            spd_d       = spd_mv;
            dir_d       = dir_mv;
            enter_crash = wall_hit;
          end
        end
        ST_CRASH: begin
          spd_d = '0;
          if (cnt_q == FCW'(CRASH_LEN - 1)) begin
            state_d = ST_RESPAWN;
            x_d     = W'(X_START);
            img_d   = W'(IMG_ALIVE);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            img_d = W'(IMG_CRASH0) + W'(cnt_inc / FCW'(FRAMES_PER_IMG));
          end
        end
        ST_RESPAWN: begin
          x_d   = x_mv;
          spd_d = spd_mv;
          dir_d = dir_mv;
          if (cnt_q == FCW'(INVULN_FRAMES - 1)) begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_ALIVE;
      endcase
      if (enter_crash) begin
        state_d = ST_CRASH;
        spd_d   = '0;
        cnt_d   = '0;
        img_d   = W'(IMG_CRASH0);
        cc_d    = (cc_q == 4'hF) ? cc_q : cc_q + 4'd1;
      end
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_ALIVE;
      x_q     <= W'(X_START);
      spd_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      img_q   <= W'(IMG_ALIVE);
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      cc_q    <= cc_d;
    end
  end

`ifdef RESPAWN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_q, blink_d;
  logic          vis_q, vis_d;

  // blink: hidden on respawn entry, toggle every BLINK_FRAMES frames, solid again in ALIVE
  always_comb begin
    blink_d = blink_q;
    vis_d   = vis_q;
    if (frame_start) begin
      if (state_q == ST_CRASH && state_d == ST_RESPAWN) begin
        blink_d = '0;
        vis_d   = 1'b0;
      end else if (state_q == ST_RESPAWN) begin
        if (state_d == ST_ALIVE) begin
          blink_d = '0;
          vis_d   = 1'b1;
        end else if (blink_q == BW'(BLINK_FRAMES - 1)) begin
          blink_d = '0;
          vis_d   = ~vis_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
    end
  end

  // blink registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  assign visible = vis_q;
`else
  assign visible = 1'b1;
`endif

  assign img_id       = img_q;
  assign player_x     = x_q;
  assign player_y     = W'(Y_POS);
  assign width        = W'(CAR_W);
  assign height       = W'(CAR_H);
  assign crashing     = (state_q == ST_CRASH);
  assign invulnerable = (state_q == ST_RESPAWN);
  assign crash_count  = cc_q;

endmodule

// File: tb/tb_player_motion_fsm.sv
// tb/tb_player_motion_fsm.sv - scoreboard bench for player_motion_fsm
module tb_player_motion_fsm;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        frame_start = 1'b0;
  logic        plus = 1'b0;
  logic        minus = 1'b0;
  logic        coll = 1'b0;
  logic [10:0] img_id, player_x, player_y, width, height;
  logic        crashing, invulnerable, visible;
  logic [3:0]  crash_count;

  player_motion_fsm dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start),
    .plus_is_pressed(plus), .minus_is_pressed(minus), .collision(coll),
    .img_id(img_id), .player_x(player_x), .player_y(player_y),
    .width(width), .height(height), .crashing(crashing),
    .invulnerable(invulnerable), .visible(visible), .crash_count(crash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int img; int crsh; int inv; int vis; int cc;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: 0 alive, 1 crash, 2 respawn
  int m_st, m_x, m_spd, m_dir, m_cnt, m_cc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 256; m_spd = 0; m_dir = 0; m_cnt = 0; m_cc = 0;
  endtask

  task automatic model_crash();
    m_st = 1; m_cnt = 0; m_spd = 0;
    m_cc = (m_cc < 15) ? m_cc + 1 : 15;
  endtask

  task automatic model_step(input bit p, input bit m, input bit c);
    bit r, l, hit;
    if (m_st == 1) begin
      m_spd = 0;
      if (m_cnt == 191) begin m_st = 2; m_x = 256; m_cnt = 0; end
      else m_cnt++;
    end else if (m_st == 0 && c) begin
      model_crash();
    end else begin
      r = p && !m; l = m && !p; hit = 0;
      if (!(r || l)) m_spd = 0;
      else begin
        if (m_spd == 0 || int'(r) != m_dir) m_spd = 1;
        else m_spd = (m_spd + 1 > 4) ? 4 : m_spd + 1;
        m_dir = r;
      end
      if (r) begin
        if (m_x + m_spd + 32 > 484) begin m_x = 452; hit = 1; end
        else m_x += m_spd;
      end else if (l) begin
        if (m_x < 242 + m_spd) begin m_x = 242; hit = 1; end
        else m_x -= m_spd;
      end
      if (m_st == 0) begin
        if (hit) model_crash();
      end else begin
        if (m_cnt == 119) begin m_st = 0; m_cnt = 0; end
        else m_cnt++;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.x    = m_x;
    e.img  = (m_st == 1) ? 99 + m_cnt / 16 : 0;
    e.crsh = (m_st == 1);
    e.inv  = (m_st == 2);
`ifdef RESPAWN_BLINK_EN
    e.vis  = (m_st == 2) ? (m_cnt / 8) % 2 : 1;
`else
    e.vis  = 1;
`endif
    e.cc   = m_cc;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("x", player_x, e.x);
      check_eq("img_id", img_id, e.img);
      check_eq("crashing", crashing, e.crsh);
      check_eq("invulnerable", invulnerable, e.inv);
      check_eq("visible", visible, e.vis);
      check_eq("crash_count", crash_count, e.cc);
    end
  endtask

  // one frame: pulse, compare one clock later, then an idle clock with noisy inputs that must be ignored
  task automatic drive_frame(input bit p, input bit m, input bit c);
    @(negedge clk);
    plus = p; minus = m; coll = c; frame_start = 1'b1;
    model_step(p, m, c);
    push_expected();
    @(negedge clk);
    frame_start = 1'b0;
    plus = 1'($urandom); minus = 1'($urandom); coll = 1'($urandom);
    compare_out();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, player_x, 256);
    check_eq({tag, "_img"}, img_id, 0);
    check_eq({tag, "_crashing"}, crashing, 0);
    check_eq({tag, "_invuln"}, invulnerable, 0);
    check_eq({tag, "_visible"}, visible, 1);
    check_eq({tag, "_cc"}, crash_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check_eq("player_y", player_y, 380);
    check_eq("width", width, 32);
    check_eq("height", height, 36);
    resetN = 1'b1;

    // acceleration to the right
    repeat (6) drive_frame(1, 0, 0);
    check_eq("x_after_6", player_x, 274);

    // keep going until the right wall clamps and crashes
    guard = 0;
    while (m_st != 1 && guard < 100) begin drive_frame(1, 0, 0); guard++; end
    check_eq("wall_x", player_x, 452);
    check_eq("wall_crashing", crashing, 1);
    check_eq("wall_img", img_id, 99);

    // crash animation ignores keys and collisions
    for (int i = 0; i < 192; i++) drive_frame(1'($urandom), 1'($urandom), 1'($urandom));
    check_eq("respawn_x", player_x, 256);
    check_eq("respawn_img", img_id, 0);
    check_eq("respawn_inv", invulnerable, 1);

    // respawn: left wall clamps without crashing, collisions ignored
    for (int i = 0; i < 10; i++) drive_frame(0, 1, 1'(i % 2));
    check_eq("respawn_clamp_x", player_x, 242);
    for (int i = 0; i < 110; i++) drive_frame(1'($urandom), 1'($urandom), 1);
    check_eq("inv_over", invulnerable, 0);
    drive_frame(0, 0, 1);
    check_eq("second_crash", crashing, 1);

    // asynchronous reset in the middle of the animation
    repeat (20) drive_frame(0, 0, 0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check_reset_vals("mid_crash_reset");
    model_reset();
    sb_q.delete();
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // both keys held: no motion
    repeat (3) drive_frame(1, 1, 0);
    check_eq("both_keys_x", player_x, 256);

    // left wall: exact arrival at 242 is legal, the following push crashes
    repeat (5) drive_frame(0, 1, 0);
    check_eq("left_exact_x", player_x, 242);
    check_eq("left_exact_alive", crashing, 0);
    drive_frame(0, 1, 0);
    check_eq("left_crash", crashing, 1);

    // repeated crashes saturate the counter
    for (int k = 0; k < 15; k++) begin
      repeat (312) drive_frame(0, 0, 0);
      drive_frame(0, 0, 1);
    end
    check_eq("cc_saturated", crash_count, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
